// File: rtl/mips_alu_arbiter.sv
// Two-requester front end for a shared MIPS ALU.
// Round-robin grant, operand latch, 1-cycle EXEC, 1-cycle DONE strobe.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req0/op0/a0/b0/c0   : requester 0 level request + operands
//   req1/op1/a1/b1/c1   : requester 1 level request + operands
//   alu_in1/in2/instc   : operands driven to the shared ALU (EXEC only)
//   alu_op              : opcode to the ALU, NOP_OP when idle/illegal
//   alu_result          : combinational ALU result
//   alu_br_taken        : combinational ALU branch decision
//   done0, done1        : one-cycle completion strobe per requester
//   result_out, br_out  : captured ALU outputs, held until next capture
//   err_out             : last transaction used an illegal opcode
//   busy                : transaction in flight (EXEC or DONE)

module mips_alu_arbiter #(
    parameter int              DATA_W = 32,
    parameter int              OP_W   = 4,
    parameter logic [OP_W-1:0] NOP_OP = 4'b1011
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic [OP_W-1:0]   op0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] c0,

    input  logic              req1,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] c1,

    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [DATA_W-1:0] alu_instc,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_br_taken,

    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result_out,
    output logic              br_out,
    output logic              err_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] ILL_LO = OP_W'(12);

    state_t state;
    state_t state_nx;

    logic              pri;
    logic              winner;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] c_q;

    logic              any_req;
    logic              gnt_id;
    logic              illegal;

    assign any_req = req0 | req1;
    assign illegal = (op_q >= ILL_LO);

    // A lone request wins outright; a tie goes to the favored side.
    always_comb begin
        gnt_id = 1'b0;
        if (req0 && req1) begin
            gnt_id = pri;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = EXEC;
            EXEC:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri        <= 1'b0;
            winner     <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            result_out <= '0;
            br_out     <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        winner <= gnt_id;
                        op_q   <= gnt_id ? op1 : op0;
                        a_q    <= gnt_id ? a1  : a0;
                        b_q    <= gnt_id ? b1  : b0;
                        c_q    <= gnt_id ? c1  : c0;
                    end
                end
                EXEC: begin
                    if (illegal) begin
                        result_out <= '0;
                        br_out     <= 1'b0;
                        err_out    <= 1'b1;
                    end else begin
                        result_out <= alu_result;
                        br_out     <= alu_br_taken;
                        err_out    <= 1'b0;
                    end
                end
                DONE: begin
                    // Favor whoever was not just served.
                    pri <= ~winner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_op    = NOP_OP;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_instc = '0;
        done0     = 1'b0;
        done1     = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            EXEC: begin
                alu_op    = illegal ? NOP_OP : op_q;
                alu_in1   = a_q;
                alu_in2   = b_q;
                alu_instc = c_q;
            end
            DONE: begin
                done0 = ~winner;
                done1 = winner;
            end
            default: ;
        endcase
    end

endmodule
